issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- Register-hazard scheduler for the ID issue point.
- Tracks every architectural register with an in-flight write between issue (ID→EXE fire) and writeback (WB→RegFile write).
- Reports per-source "pending" and "load-pending" status so ID can decide between bypass and stall.
- Throttles issue when a destination's in-flight counter would overflow. Sits beside the wake-up logic in ID; it does not drive data.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).
- CW, 2, width of the per-register in-flight counter; max in-flight writes = 2^CW-1.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous active-high reset.
- issue_fire  in  1  ID instruction accepted by EXE this cycle (ID_to_EXE_valid & EXE_allow_in).
- issue_w_en  in  1  issuing instruction writes the RegFile.
- issue_w_addr  in  AW  destination of the issuing instruction.
- issue_is_load  in  1  issuing instruction's result comes from data RAM.
- load_done  in  1  load data available on the MEM bypass this cycle.
- load_done_addr  in  AW  destination of that load.
- retire_en  in  1  WB writes the RegFile this cycle (same as RegFile w_en).
- retire_addr  in  AW  WB write address.
- sb_clear  in  1  synchronous clear of all tracking (pipeline flush behind ID).
- r_addr1  in  AW  ID source 1 register.
- r_addr2  in  AW  ID source 2 register.
- dst_addr  in  AW  ID destination register (for the overflow check).
- dst_w_en  in  1  ID instruction writes a register.
- src1_pending  out  1  r_addr1 has ≥1 in-flight write.
- src2_pending  out  1  r_addr2 has ≥1 in-flight write.
- src1_load_wait  out  1  youngest writer of r_addr1 is a load whose data is not yet available.
- src2_load_wait  out  1  same, for r_addr2.
- issue_block  out  1  dst counter saturated; ID must not issue.
- sb_busy  out  1  any register has a nonzero count.

Behaviour:
- State per register i (i≠0):
  - cnt[i], CW bits.
  - ldw[i], 1 bit: youngest in-flight writer is an unresolved load.
- Register 0 is never tracked. cnt[0] and ldw[0] are constant 0. Issue/retire/load_done to address 0 are ignored.
- Reset (reset=1 at posedge): all cnt=0 and all ldw=0. All outputs are 0 in the cycle after reset (outputs are combinational from state).
- sb_clear=1: same effect as reset on the next edge. It has priority over any simultaneous issue, retire or load_done.
- Counter update each edge, for each i≠0:
  - inc = issue_fire & issue_w_en & issue_w_addr==i.
  - dec = retire_en & retire_addr==i.
  - inc & !dec → cnt+1.
  - dec & !inc → cnt-1.
  - both or neither → unchanged.
- Saturation rules:
  - Increment at cnt = 2^CW-1 is impossible by protocol, because issue_block prevents it.
  - A decrement at 0 is a protocol error. cnt holds at 0 (no wrap); a simulation assertion fires.
- ldw update, same edge, for each i≠0:
  - If inc: ldw ← issue_is_load (the youngest writer overrides).
  - Else if load_done & load_done_addr==i: ldw ← 0.
  - Else if dec & cnt==1: ldw ← 0.
  - Otherwise ldw holds.
  - If inc and load_done hit the same register in the same cycle, the new issue wins (ldw ← issue_is_load).
- Outputs (combinational from current state; 0-cycle query latency):
  - srcN_pending = (r_addrN≠0) & cnt[r_addrN]≠0.
  - srcN_load_wait = (r_addrN≠0) & ldw[r_addrN].
  - issue_block = dst_w_en & dst_addr≠0 & cnt[dst_addr]==2^CW-1.
  - sb_busy = OR of all cnt≠0.
- Same-cycle retire and query: the query sees the pre-edge count. WB data is bypassed by ID, so this is correct.
- Stall contract for ID: ID_ready_go must be deasserted when any of the following holds:
  - src1_load_wait, for a register source.
  - src2_load_wait, for a register source.
  - issue_block.
- Latency: state reflects an issue or retire one cycle after the fire edge.

Decomposition:
- Shared header (myCPU.h): `SB_AW, `SB_CW, `NREG, and the widths of any bus bundling the scoreboard inputs (`ID_TO_SB_BUS_WD, `WB_TO_SB_BUS_WD).
- Natural sub-module sb_entry: one register's cnt/ldw update logic. It takes inc, dec, ld_set, ld_clr and clear, and is instantiated NREG-1 times by generate.

Test Plan:
- Reset then query r1/r2 = 5/6 → all outputs 0. sb_busy=0.
- Issue add to r5, r_addr1=5 on the next cycle → src1_pending=1, src1_load_wait=0. Retire r5 three cycles later → src1_pending=0 next cycle, sb_busy=0.
- Issue ld.w to r7, then query r_addr2=7 → src2_load_wait=1. Assert load_done with addr 7 → src2_load_wait=0 next cycle, src2_pending still 1 until retire.
- Issue three writes to r3 back-to-back with no retire → cnt=3, and dst_addr=3 with dst_w_en=1 → issue_block=1. Retire r3 once → issue_block=0.
- Same cycle: issue to r4 and retire r4 with cnt=1 → cnt stays 1, src1_pending=1. Also, issue load to r9 while load_done for r9 in the same cycle → ldw[9]=1.
- Issue to r0 and r8, then assert sb_clear with a simultaneous issue to r8 → r0 never pending, and after the clear edge all cnt=0, sb_busy=0.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Purpose: shared sizing for the ID-stage register hazard scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package issue_scoreboard_pkg;

    localparam int SB_NREG = 32;  // architectural registers
    localparam int SB_AW   = 5;   // register address width
    localparam int SB_CW   = 2;   // in-flight counter width per register

    // Largest number of writes that may be in flight to one register.
    localparam int SB_CNT_MAX = (1 << SB_CW) - 1;

endpackage

// File: rtl/issue_scoreboard_sb_entry.sv
// Purpose: in-flight write counter and load-wait flag for one architectural register.
// Latency: state reflects inc/dec/load events one cycle after the edge that samples them.
// Backpressure: none here; the parent raises issue_block before the counter can saturate.
module issue_scoreboard_sb_entry #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,     // a new writer of this register issues
    input  logic          dec,     // a writer of this register retires
    input  logic          ld_set,  // the issuing writer is a load
    input  logic          ld_clr,  // load data for this register is on the bypass
    output logic [CW-1:0] cnt,
    output logic          ldw
);

    // Counter and youngest-writer load flag; flush and reset share one path.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
            ldw <= 1'b0;
        end else begin
            // Simultaneous issue and retire cancel out.
            if (inc && !dec) begin
                cnt <= cnt + 1'b1;
            end else if (dec && !inc && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            // The youngest writer decides ldw, so a fresh issue beats a load_done.
            if (inc) begin
                ldw <= ld_set;
            end else if (ld_clr) begin
                ldw <= 1'b0;
            end else if (dec && (cnt == CW'(1))) begin
                ldw <= 1'b0;
            end
        end
    end

    // Retiring a register that has nothing in flight means the pipeline lost track.
    a_no_underflow : assert property (@(posedge clk) disable iff (reset || clear)
        !(dec && !inc && (cnt == '0)));

endmodule

// File: rtl/issue_scoreboard.sv
// Purpose: tracks in-flight register writes between issue and writeback for ID hazard checks.
// Latency: queries are combinational from state; issue/retire become visible one cycle later.
// Backpressure: issue_block asks ID to hold when the destination counter is saturated.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG = SB_NREG,
    parameter int AW   = SB_AW,
    parameter int CW   = SB_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_fire,
    input  logic          issue_w_en,
    input  logic [AW-1:0] issue_w_addr,
    input  logic          issue_is_load,
    input  logic          load_done,
    input  logic [AW-1:0] load_done_addr,
    input  logic          retire_en,
    input  logic [AW-1:0] retire_addr,
    input  logic          sb_clear,
    input  logic [AW-1:0] r_addr1,
    input  logic [AW-1:0] r_addr2,
    input  logic [AW-1:0] dst_addr,
    input  logic          dst_w_en,
    output logic          src1_pending,
    output logic          src2_pending,
    output logic          src1_load_wait,
    output logic          src2_load_wait,
    output logic          issue_block,
    output logic          sb_busy
);

    logic [CW-1:0] cnt [NREG];
    logic          ldw [NREG];

    // r0 is hardwired to zero, so writes to it never create a hazard.
    assign cnt[0] = '0;
    assign ldw[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        logic inc;
        logic dec;
        logic ld_clr;

        assign inc    = issue_fire && issue_w_en && (issue_w_addr == AW'(i));
        assign dec    = retire_en && (retire_addr == AW'(i));
        assign ld_clr = load_done && (load_done_addr == AW'(i));

        issue_scoreboard_sb_entry #(
            .CW (CW)
        ) u_entry (
            .clk    (clk),
            .reset  (reset),
            .clear  (sb_clear),
            .inc    (inc),
            .dec    (dec),
            .ld_set (issue_is_load),
            .ld_clr (ld_clr),
            .cnt    (cnt[i]),
            .ldw    (ldw[i])
        );
    end

    // Source/destination queries see pre-edge state; WB data is bypassed by ID.
    always_comb begin
        src1_pending   = (r_addr1 != '0) && (cnt[r_addr1] != '0);
        src2_pending   = (r_addr2 != '0) && (cnt[r_addr2] != '0);
        src1_load_wait = (r_addr1 != '0) && ldw[r_addr1];
        src2_load_wait = (r_addr2 != '0) && ldw[r_addr2];
        issue_block    = dst_w_en && (dst_addr != '0) && (cnt[dst_addr] == '1);
    end

    // Busy whenever any register still has a write in flight.
    always_comb begin
        sb_busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            sb_busy = sb_busy | (cnt[i] != '0);
        end
    end

endmodule
